// File: rtl/hdd_dma_pkg.sv
// Shared types and constants for the HDD block-request controller.
package hdd_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOMEDIA = 2'd1;
  localparam logic [1:0] ERR_WP      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef struct packed {
    op_t         op;
    logic        unit;
    logic [15:0] sector;
  } req_t;

endpackage

// File: rtl/hdd_req_slot.sv
// One-deep pending request register with sticky overflow flag.
module hdd_req_slot
  import hdd_dma_pkg::*;
(
  input  logic clk_sys,
  input  logic reset_n,
  input  logic push,
  input  req_t push_req,
  input  logic pop,
  input  logic drop,
  output logic full,
  output req_t slot_req,
  output logic overflow
);

  logic room;

  // The slot frees up in the same cycle it is popped, so a push can land then.
  always_comb begin
    room = ~full | pop;
  end

  // Slot storage and sticky overflow; drop flags a request that had no place.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      full     <= 1'b0;
      slot_req <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && room) begin
        full     <= 1'b1;
        slot_req <= push_req;
      end else if (pop) begin
        full <= 1'b0;
      end
      if ((push && !room) || drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdd_dma_ctrl.sv
// HDD request controller: latches core block requests, routes them to one of
// two SD host units, tracks the ack handshake and stalls the CPU meanwhile.
module hdd_dma_ctrl
  import hdd_dma_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic        hdd_unit,
  input  logic [15:0] hdd_sector,
  input  logic [1:0]  img_mounted,
  input  logic        img_size_nz,
  input  logic        img_readonly,
  input  logic [1:0]  sd_ack,
  input  logic        sd_buff_wr,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  output logic        hdd_ram_we,
  output logic        cpu_wait,
  output logic [1:0]  hdd_mounted,
  output logic [1:0]  hdd_protect,
  output logic        busy,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic        overflow
);

  state_t      state;
  logic        active_unit;
  logic [15:0] sector_q;
  logic [23:0] wd;
  logic [1:0]  ack_prev = '0;
  logic [1:0]  mounted_q = '0;
  logic [1:0]  protect_q = '0;

  req_t rd_req, wr_req, in0, in1, acc, push_req, slot_req;
  logic in0_v, in1_v, idle, take_new, acc_v, pop, push, drop, slot_full;
  logic ack_cur, ack_rise, ack_fall, wd_expire, rej_nomedia, rej_wp;
  logic [24:0] wd_inc;
  logic [1:0]  unit_mask;

  // Split incoming pulses into an ordered pair (read first) and decide which
  // one is accepted directly and which one, if any, goes to the pending slot.
  always_comb begin
    rd_req   = '{op: OP_READ,  unit: hdd_unit, sector: hdd_sector};
    wr_req   = '{op: OP_WRITE, unit: hdd_unit, sector: hdd_sector};
    in0_v    = hdd_read | hdd_write;
    in0      = hdd_read ? rd_req : wr_req;
    in1_v    = hdd_read & hdd_write;
    in1      = wr_req;
    idle     = (state == IDLE);
    pop      = idle & slot_full;
    take_new = idle & ~slot_full & in0_v;
    acc_v    = pop | take_new;
    acc      = slot_full ? slot_req : in0;
    if (take_new) begin
      push     = in1_v;
      push_req = in1;
      drop     = 1'b0;
    end else begin
      push     = in0_v;
      push_req = in0;
      drop     = in1_v;
    end
    rej_nomedia = ~mounted_q[acc.unit];
    rej_wp      = (acc.op == OP_WRITE) & protect_q[acc.unit];
    unit_mask   = acc.unit ? 2'b10 : 2'b01;
  end

  // Ack edge detection on the active unit only, plus watchdog expiry test.
  always_comb begin
    ack_cur   = sd_ack[active_unit];
    ack_rise  = ack_cur & ~ack_prev[active_unit];
    ack_fall  = ~ack_cur & ack_prev[active_unit];
    wd_inc    = {1'b0, wd} + 25'd1;
    wd_expire = (TIMEOUT_CYCLES != 24'd0) && (wd_inc >= {1'b0, TIMEOUT_CYCLES});
  end

  hdd_req_slot u_slot (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .drop     (drop),
    .full     (slot_full),
    .slot_req (slot_req),
    .overflow (overflow)
  );

  // Previous ack levels for edge detection; harmless outside REQ/XFER.
  always_ff @(posedge clk_sys) begin
    ack_prev <= sd_ack;
  end

  // Per-unit media status follows the mount strobe and survives reset_n.
  always_ff @(posedge clk_sys) begin
    for (int unsigned u = 0; u < 2; u++) begin
      if (img_mounted[u]) begin
        mounted_q[u] <= img_size_nz;
        protect_q[u] <= img_readonly;
      end
    end
  end

  // Request FSM with registered host requests, stall, error and watchdog.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      sd_rd       <= '0;
      sd_wr       <= '0;
      sector_q    <= '0;
      active_unit <= 1'b0;
      cpu_wait    <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_NONE;
      wd          <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_v) begin
            if (rej_nomedia) begin
              err_code  <= ERR_NOMEDIA;
              err_pulse <= 1'b1;
            end else if (rej_wp) begin
              err_code  <= ERR_WP;
              err_pulse <= 1'b1;
            end else begin
              active_unit <= acc.unit;
              sector_q    <= acc.sector;
              if (acc.op == OP_WRITE) sd_wr <= unit_mask;
              else                    sd_rd <= unit_mask;
              cpu_wait <= 1'b1;
              wd       <= '0;
              state    <= REQ;
            end
          end
        end
        REQ, XFER: begin
          if (wd_expire) begin
            sd_rd     <= '0;
            sd_wr     <= '0;
            cpu_wait  <= 1'b0;
            err_code  <= ERR_TIMEOUT;
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else begin
            wd <= (wd == '1) ? wd : wd + 24'd1;
            if (state == REQ) begin
              if (ack_rise) begin
                sd_rd <= '0;
                sd_wr <= '0;
                state <= XFER;
              end
            end else if (ack_fall) begin
              cpu_wait <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sd_lba      = {16'h0000, sector_q};
    hdd_ram_we  = sd_buff_wr & sd_ack[active_unit];
    busy        = (state != IDLE);
    hdd_mounted = mounted_q;
    hdd_protect = protect_q;
  end

endmodule
